// File: rtl/qam_framer.sv
// 4-QAM transmit framer: emits a fixed head, then encoder payload symbols mapped
// to signed 4-bit I/Q levels, then an idle gap, one symbol per clock.
module qam_framer #(
    parameter int         HEAD_LEN    = 8,
    parameter logic [1:0] HEAD_SYM    = 2'b11,
    parameter int         PAYLOAD_LEN = 16,
    parameter int         GAP_LEN     = 4,
    parameter int         AMP         = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [1:0] conv_in,
    input  logic       conv_valid,
    output logic       conv_ready,
    output logic [3:0] I_send,
    output logic [3:0] Q_send,
    output logic       tx_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        PAYLOAD,
        GAP
    } state_t;

    localparam logic [7:0] HEAD_LAST    = 8'(HEAD_LEN - 1);
    localparam logic [7:0] PAYLOAD_LAST = 8'(PAYLOAD_LEN - 1);
    localparam logic [7:0] GAP_LAST     = 8'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);
    localparam logic       NO_GAP       = (GAP_LEN == 0);
    localparam logic [3:0] LEVEL_POS    = 4'(AMP);
    localparam logic [3:0] LEVEL_NEG    = 4'(-AMP);

    state_t     state, state_next;
    logic [7:0] sym_cnt, sym_cnt_next;
    logic [3:0] i_next, q_next;
    logic       valid_next, done_next, underrun_next;

    function automatic logic [3:0] level(input logic b);
        return b ? LEVEL_POS : LEVEL_NEG;
    endfunction

    // Next state, counter and the values the output register loads at this edge.
    always_comb begin
        state_next    = state;
        sym_cnt_next  = sym_cnt + 8'd1;
        i_next        = 4'd0;
        q_next        = 4'd0;
        valid_next    = 1'b0;
        done_next     = 1'b0;
        underrun_next = underrun;
        case (state)
            IDLE: begin
                sym_cnt_next = 8'd0;
                if (tx_start) begin
                    state_next    = HEAD;
                    underrun_next = 1'b0;
                end
            end
            HEAD: begin
                i_next     = level(HEAD_SYM[1]);
                q_next     = level(HEAD_SYM[0]);
                valid_next = 1'b1;
                if (sym_cnt == HEAD_LAST) begin
                    state_next   = PAYLOAD;
                    sym_cnt_next = 8'd0;
                end
            end
            PAYLOAD: begin
                valid_next = 1'b1;
                // A missing encoder symbol still occupies its slot as a zero level.
                if (conv_valid) begin
                    i_next = level(conv_in[1]);
                    q_next = level(conv_in[0]);
                end else begin
                    underrun_next = 1'b1;
                end
                if (sym_cnt == PAYLOAD_LAST) begin
                    sym_cnt_next = 8'd0;
                    if (NO_GAP) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (sym_cnt == GAP_LAST) begin
                    state_next   = IDLE;
                    sym_cnt_next = 8'd0;
                    done_next    = 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                sym_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sym_cnt    <= 8'd0;
            I_send     <= 4'd0;
            Q_send     <= 4'd0;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_next;
            sym_cnt    <= sym_cnt_next;
            I_send     <= i_next;
            Q_send     <= q_next;
            tx_valid   <= valid_next;
            frame_done <= done_next;
            underrun   <= underrun_next;
        end
    end

    assign conv_ready = (state == PAYLOAD);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_qam_framer.sv
// Directed bench for qam_framer: default-parameter instance plus a
// HEAD_LEN=1 / PAYLOAD_LEN=1 / GAP_LEN=0 instance, hand-computed expectations.
module tb_qam_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start, conv_valid;
    logic [1:0] conv_in;
    logic       conv_ready, tx_valid, busy, frame_done, underrun;
    logic [3:0] I_send, Q_send;

    logic       s_tx_start, s_conv_valid;
    logic [1:0] s_conv_in;
    logic       s_conv_ready, s_tx_valid, s_busy, s_frame_done, s_underrun;
    logic [3:0] s_I_send, s_Q_send;

    int checks = 0;
    int errors = 0;

    qam_framer dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .conv_in(conv_in),
        .conv_valid(conv_valid), .conv_ready(conv_ready), .I_send(I_send),
        .Q_send(Q_send), .tx_valid(tx_valid), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    qam_framer #(.HEAD_LEN(1), .PAYLOAD_LEN(1), .GAP_LEN(0)) dut_short (
        .clk(clk), .reset(reset), .tx_start(s_tx_start), .conv_in(s_conv_in),
        .conv_valid(s_conv_valid), .conv_ready(s_conv_ready), .I_send(s_I_send),
        .Q_send(s_Q_send), .tx_valid(s_tx_valid), .busy(s_busy),
        .frame_done(s_frame_done), .underrun(s_underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic valid, input logic [1:0] sym);
        tx_start   = start;
        conv_valid = valid;
        conv_in    = sym;
        stepClock();
    endtask

    // {tx_valid, I, Q} packed for compact comparisons
    function automatic logic [31:0] txWord();
        return 32'({tx_valid, I_send, Q_send});
    endfunction

    function automatic logic [31:0] symWord(input logic [1:0] s);
        return 32'({1'b1, s[1] ? 4'h3 : 4'hD, s[0] ? 4'h3 : 4'hD});
    endfunction

    // One frame with default parameters; payload slots drop_lo..drop_hi have conv_valid low.
    task automatic runFrame(input int drop_lo, input int drop_hi, input logic poke, input string tag);
        int   valid_cnt = 0;
        int   done_cnt  = 0;
        logic drop;
        logic [1:0] sym;
        applyStimulus(1'b1, 1'b0, 2'b00);
        checkOutput({tag, " busy_after_start"}, 32'(busy), 32'd1);
        checkOutput({tag, " no_early_symbol"}, txWord(), 32'd0);
        checkOutput({tag, " underrun_cleared"}, 32'(underrun), 32'd0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(poke && (k == 3), 1'b0, 2'b00);
            checkOutput({tag, " head"}, txWord(), symWord(2'b11));
            if (tx_valid) valid_cnt++;
        end
        for (int j = 0; j < 16; j++) begin
            drop = (j >= drop_lo) && (j <= drop_hi);
            sym  = 2'(j);
            checkOutput({tag, " ready_payload"}, 32'(conv_ready), 32'd1);
            applyStimulus(1'b0, !drop, sym);
            checkOutput({tag, " payload"}, txWord(), drop ? 32'h100 : symWord(sym));
            checkOutput({tag, " underrun"}, 32'(underrun), 32'(j >= drop_lo));
            if (tx_valid) valid_cnt++;
        end
        for (int g = 0; g < 4; g++) begin
            applyStimulus(poke && (g == 1), 1'b0, 2'b00);
            checkOutput({tag, " gap"}, txWord(), 32'd0);
            checkOutput({tag, " gap_ready"}, 32'(conv_ready), 32'd0);
            checkOutput({tag, " gap_busy"}, 32'(busy), 32'(g != 3));
            if (frame_done) done_cnt++;
        end
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1'b0, 1'b0, 2'b00);
            checkOutput({tag, " idle_after"}, 32'({busy, tx_valid}), 32'd0);
            if (frame_done) done_cnt++;
        end
        checkOutput({tag, " valid_count"}, 32'(valid_cnt), 32'd24);
        checkOutput({tag, " done_count"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, " underrun_end"}, 32'(underrun), 32'(drop_lo < 16));
    endtask

    initial begin
        int done_cnt, vrun, gap, vruns, ready_cnt, ready_bad, cyc;
        logic prev_v;

        reset = 1'b1;
        s_tx_start = 1'b0; s_conv_valid = 1'b0; s_conv_in = 2'b00;
        applyStimulus(1'b0, 1'b0, 2'b00);
        applyStimulus(1'b1, 1'b1, 2'b11);
        checkOutput("reset tx", txWord(), 32'd0);
        checkOutput("reset flags", 32'({conv_ready, busy, frame_done, underrun}), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00);

        runFrame(99, 98, 1'b0, "basic");
        runFrame(5, 6, 1'b0, "drop");
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("underrun sticky_idle", 32'(underrun), 32'd1);
        runFrame(99, 98, 1'b1, "poke");

        // Abort at payload slot 3 after an underrun in slot 1.
        applyStimulus(1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, k != 1, 2'(k));
        checkOutput("abort pre_underrun", 32'(underrun), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 2'b11);
        reset = 1'b0;
        checkOutput("abort tx", txWord(), 32'd0);
        checkOutput("abort flags", 32'({conv_ready, busy, frame_done, underrun}), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 2'b00);
            if (frame_done) done_cnt++;
        end
        checkOutput("abort no_done", 32'(done_cnt), 32'd0);
        runFrame(99, 98, 1'b0, "after_reset");

        // tx_start held high for three frames.
        done_cnt = 0; vrun = 0; gap = 0; vruns = 0; ready_cnt = 0; ready_bad = 0; cyc = 0;
        prev_v = 1'b0;
        while (done_cnt < 3 && cyc < 200) begin
            applyStimulus(1'b1, 1'b1, 2'(cyc));
            cyc++;
            if (frame_done) done_cnt++;
            if (conv_ready) begin
                ready_cnt++;
                if (!tx_valid) ready_bad++;
            end
            if (tx_valid) begin
                if (!prev_v && vruns > 0) checkOutput("b2b gap_len", 32'(gap), 32'd5);
                vrun++;
                gap = 0;
            end else begin
                if (prev_v) begin
                    checkOutput("b2b frame_len", 32'(vrun), 32'd24);
                    vruns++;
                    vrun = 0;
                end
                gap++;
            end
            prev_v = tx_valid;
        end
        checkOutput("b2b frames", 32'(done_cnt), 32'd3);
        checkOutput("b2b valid_runs", 32'(vruns), 32'd3);
        checkOutput("b2b ready_cycles", 32'(ready_cnt), 32'd48);
        checkOutput("b2b ready_outside", 32'(ready_bad), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("b2b stop", 32'(busy), 32'd0);

        // Minimal frame: one head symbol, one payload symbol, no gap.
        s_tx_start = 1'b1;
        stepClock();
        s_tx_start = 1'b0;
        checkOutput("short busy", 32'(s_busy), 32'd1);
        checkOutput("short no_early", 32'(s_tx_valid), 32'd0);
        stepClock();
        checkOutput("short head", 32'({s_tx_valid, s_I_send, s_Q_send}), 32'h133);
        checkOutput("short ready", 32'(s_conv_ready), 32'd1);
        s_conv_valid = 1'b1;
        s_conv_in    = 2'b10;
        stepClock();
        s_conv_valid = 1'b0;
        checkOutput("short payload", 32'({s_tx_valid, s_I_send, s_Q_send}), 32'h13D);
        checkOutput("short done", 32'(s_frame_done), 32'd1);
        checkOutput("short busy_low", 32'(s_busy), 32'd0);
        stepClock();
        checkOutput("short after", 32'({s_tx_valid, s_frame_done, s_busy}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
